// File: rtl/me_pkg.sv
// Shared types and derived-width helpers for the motion-estimation minimum search.
package me_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } me_state_e;

   function automatic int pos_count(input int tb_length, input int sw_length);
      return sw_length - tb_length + 1;
   endfunction

   // A zero-width bus is illegal, so degenerate geometries still get one bit.
   function automatic int at_least_one(input int w);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int cnt_width(input int tb_length, input int sw_length);
      return at_least_one($clog2(pos_count(tb_length, sw_length) * pos_count(tb_length, sw_length)));
   endfunction

   function automatic int pos_width(input int tb_length, input int sw_length);
      return at_least_one($clog2(pos_count(tb_length, sw_length)));
   endfunction

   function automatic int mvec_width(input int tb_length, input int sw_length);
      return 2 * pos_width(tb_length, sw_length);
   endfunction

   function automatic int sad_width(input int tb_length, input int pe_out_width);
      return $clog2(tb_length * tb_length) + pe_out_width;
   endfunction

endpackage

// File: rtl/me_raster_counter.sv
// Raster-order candidate counter: linear index plus {y,x}, wrapping to 0 after the last candidate.
module me_raster_counter #(
   parameter int POS       = 49,
   parameter int CNT_WIDTH = 12,
   parameter int POS_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 advance,
   output logic [CNT_WIDTH-1:0] idx,
   output logic [POS_WIDTH-1:0] x,
   output logic [POS_WIDTH-1:0] y,
   output logic                 last
);

   localparam int NUM_CAND = POS * POS;

   logic [CNT_WIDTH-1:0] idx_d, idx_q;
   logic [POS_WIDTH-1:0] x_d, x_q;
   logic [POS_WIDTH-1:0] y_d, y_q;
   logic                 x_wrap;

   assign x_wrap = (x_q == POS_WIDTH'(POS - 1));
   assign last   = (idx_q == CNT_WIDTH'(NUM_CAND - 1));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      idx_d = idx_q;
      x_d   = x_q;
      y_d   = y_q;
      if (clear || (advance && last)) begin
         idx_d = '0;
         x_d   = '0;
         y_d   = '0;
      end else if (advance) begin
         idx_d = idx_q + CNT_WIDTH'(1);
         x_d   = x_wrap ? '0 : x_q + POS_WIDTH'(1);
         y_d   = x_wrap ? y_q + POS_WIDTH'(1) : y_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         idx_q <= idx_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   assign idx = idx_q;
   assign x   = x_q;
   assign y   = y_q;

endmodule

// File: rtl/me_min_search_responder.sv
// 4-phase req/ack responder that tracks the minimum candidate SAD and commits its index and vector.
// Optional watchdog: define ME_TIMEOUT_EN to abort a stalled SEARCH into DONE with err set.
module me_min_search_responder
   import me_pkg::*;
#(
   parameter int  TB_LENGTH      = 16,
   parameter int  SW_LENGTH      = 64,
   parameter int  PE_OUT_WIDTH   = 8,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int POS            = pos_count(TB_LENGTH, SW_LENGTH),
   localparam int CNT_WIDTH      = cnt_width(TB_LENGTH, SW_LENGTH),
   localparam int POS_WIDTH      = pos_width(TB_LENGTH, SW_LENGTH),
   localparam int MVEC_WIDTH     = mvec_width(TB_LENGTH, SW_LENGTH),
   localparam int SAD_WIDTH      = sad_width(TB_LENGTH, PE_OUT_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  sad_valid,
   input  logic [SAD_WIDTH-1:0]  sad_in,
   output logic                  search_start,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  min_cnt,
   output logic [SAD_WIDTH-1:0]  min_sad,
   output logic [MVEC_WIDTH-1:0] min_mvec,
   output logic                  ack,
   output logic                  err
);

   if (SW_LENGTH < TB_LENGTH || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("me_min_search_responder: invalid geometry or timeout");
   end

   me_state_e state_d, state_q;
   logic      search_start_d, search_start_q;
   logic      ack_d, ack_q;

   logic [SAD_WIDTH-1:0]  work_min_d, work_min_q;
   logic [CNT_WIDTH-1:0]  work_idx_d, work_idx_q;
   logic [MVEC_WIDTH-1:0] work_mvec_d, work_mvec_q;
   logic [CNT_WIDTH-1:0]  min_cnt_d, min_cnt_q;
   logic [SAD_WIDTH-1:0]  min_sad_d, min_sad_q;
   logic [MVEC_WIDTH-1:0] min_mvec_d, min_mvec_q;

   logic                  cnt_clear, cnt_advance, cnt_last;
   logic [CNT_WIDTH-1:0]  cnt_idx;
   logic [POS_WIDTH-1:0]  cnt_x, cnt_y;

   logic                  better;
   logic [SAD_WIDTH-1:0]  cand_min;
   logic [CNT_WIDTH-1:0]  cand_idx;
   logic [MVEC_WIDTH-1:0] cand_mvec;

`ifdef ME_TIMEOUT_EN
   localparam int IDLE_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_WIDTH-1:0] idle_cnt_d, idle_cnt_q;
   logic                  err_d, err_q;
`endif

   me_raster_counter #(
      .POS       (POS),
      .CNT_WIDTH (CNT_WIDTH),
      .POS_WIDTH (POS_WIDTH)
   ) u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .advance (cnt_advance),
      .idx     (cnt_idx),
      .x       (cnt_x),
      .y       (cnt_y),
      .last    (cnt_last)
   );

   // Strict compare keeps the earliest candidate on ties.
   assign better    = (sad_in < work_min_q);
   assign cand_min  = better ? sad_in : work_min_q;
   assign cand_idx  = better ? cnt_idx : work_idx_q;
   assign cand_mvec = better ? {cnt_y, cnt_x} : work_mvec_q;

   always_comb begin
      state_d        = state_q;
      search_start_d = 1'b0;
      ack_d          = ack_q;
      work_min_d     = work_min_q;
      work_idx_d     = work_idx_q;
      work_mvec_d    = work_mvec_q;
      min_cnt_d      = min_cnt_q;
      min_sad_d      = min_sad_q;
      min_mvec_d     = min_mvec_q;
      cnt_clear      = 1'b0;
      cnt_advance    = 1'b0;
`ifdef ME_TIMEOUT_EN
      err_d          = err_q;
      idle_cnt_d     = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d        = SEARCH;
               search_start_d = 1'b1;
               work_min_d     = '1;
               work_idx_d     = '0;
               work_mvec_d    = '0;
               cnt_clear      = 1'b1;
            end
         end
         SEARCH: begin
            // A falling req wins over a coincident sample; partial results are dropped.
            if (!req) begin
               state_d = IDLE;
            end else if (sad_valid) begin
               cnt_advance = 1'b1;
               work_min_d  = cand_min;
               work_idx_d  = cand_idx;
               work_mvec_d = cand_mvec;
               if (cnt_last) begin
                  min_sad_d  = cand_min;
                  min_cnt_d  = cand_idx;
                  min_mvec_d = cand_mvec;
                  ack_d      = 1'b1;
                  state_d    = DONE;
               end
`ifdef ME_TIMEOUT_EN
            end else if (idle_cnt_q == IDLE_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               min_sad_d  = work_min_q;
               min_cnt_d  = work_idx_q;
               min_mvec_d = work_mvec_q;
               ack_d      = 1'b1;
               err_d      = 1'b1;
               state_d    = DONE;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_WIDTH'(1);
`endif
            end
         end
         DONE: begin
            if (!req) begin
               state_d = IDLE;
               ack_d   = 1'b0;
`ifdef ME_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         search_start_q <= 1'b0;
         ack_q          <= 1'b0;
         work_min_q     <= '0;
         work_idx_q     <= '0;
         work_mvec_q    <= '0;
         min_cnt_q      <= '0;
         min_sad_q      <= '0;
         min_mvec_q     <= '0;
      end else begin
         state_q        <= state_d;
         search_start_q <= search_start_d;
         ack_q          <= ack_d;
         work_min_q     <= work_min_d;
         work_idx_q     <= work_idx_d;
         work_mvec_q    <= work_mvec_d;
         min_cnt_q      <= min_cnt_d;
         min_sad_q      <= min_sad_d;
         min_mvec_q     <= min_mvec_d;
      end
   end

`ifdef ME_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         err_q      <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign search_start = search_start_q;
   assign busy         = (state_q == SEARCH);
   assign ack          = ack_q;
   assign min_cnt      = min_cnt_q;
   assign min_sad      = min_sad_q;
   assign min_mvec     = min_mvec_q;

endmodule
